counter_sequencer: RTL

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer_pkg.sv | 24 ++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/counter_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/counter_sequencer_pkg.sv
// rtl/counter_sequencer_pkg.sv - shared mode codes, state encoding and command type
package counter_sequencer_pkg;

  localparam logic [1:0] MODE_STOP    = 2'b00;
  localparam logic [1:0] MODE_INC_ONE = 2'b01;
  localparam logic [1:0] MODE_DEC_TWO = 2'b11;
  localparam logic [1:0] MODE_LOAD    = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] arg;
  } cmd_t;

  // LOAD is a single-cycle command; the others repeat arg+1 times.
  function automatic logic [3:0] initial_remaining(input cmd_t c);
    return (c.op == MODE_LOAD) ? 4'd0 : c.arg;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - command FIFO with synchronous flush and occupancy level
module cmd_fifo
  import counter_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       flush,
  input  logic       push,
  input  cmd_t       push_data,
  input  logic       pop,
  output cmd_t       head,
  output logic       full,
  output logic       empty,
  output logic [3:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t           mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [3:0]     count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == 4'(DEPTH));
  assign empty   = (count == 4'd0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - queued command sequencer driving a mod-9 counter
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       sync_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  input  logic       pause,
  output logic [1:0] mode,
  output logic [3:0] load_val,
  output logic       busy,
  output logic       done,
  output logic [3:0] fifo_level
);

  seq_state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] arg_q, arg_d;
  logic [3:0] rem_q, rem_d;
  logic       ran_q, ran_d;
  logic [1:0] mode_d;
  logic [3:0] load_d;
  logic       busy_d;
  logic       done_d;
  logic       start;
  logic       fifo_full;
  logic       fifo_empty;
  cmd_t       head;
  cmd_t       push_data;

  assign cmd_ready = !fifo_full;
  assign push_data = '{op: cmd_op, arg: cmd_arg};

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .async_reset(async_reset),
    .flush      (sync_reset),
    .push       (cmd_valid),
    .push_data  (push_data),
    .pop        (start),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  // ran_q marks a cycle that actually executed; paused cycles make no progress.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    arg_d   = arg_q;
    rem_d   = rem_q;
    start   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: start = !fifo_empty && !pause;
      ST_EXEC: begin
        if (ran_q) begin
          if (rem_q == 4'd0) begin
            done_d = 1'b1;
            if (!fifo_empty && !pause) start   = 1'b1;
            else                       state_d = ST_IDLE;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
      end
    endcase

    if (start) begin
      state_d = ST_EXEC;
      op_d    = head.op;
      arg_d   = head.arg;
      rem_d   = initial_remaining(head);
    end

    ran_d  = (state_d == ST_EXEC) && !pause;
    busy_d = (state_d == ST_EXEC);
    mode_d = ran_d ? op_d : MODE_STOP;
    load_d = (ran_d && op_d == MODE_LOAD) ? arg_d : 4'd0;

    if (sync_reset) begin
      state_d = ST_IDLE;
      op_d    = MODE_STOP;
      arg_d   = 4'd0;
      rem_d   = 4'd0;
      ran_d   = 1'b0;
      busy_d  = 1'b0;
      mode_d  = MODE_STOP;
      load_d  = 4'd0;
      done_d  = 1'b0;
      start   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q  <= ST_IDLE;
      op_q     <= MODE_STOP;
      arg_q    <= 4'd0;
      rem_q    <= 4'd0;
      ran_q    <= 1'b0;
      mode     <= MODE_STOP;
      load_val <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      rem_q    <= rem_d;
      ran_q    <= ran_d;
      mode     <= mode_d;
      load_val <= load_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule
